// File: rtl/csa_accum_cpa_19.sv
// Carry-save frame accumulator behind the 19-bit 4:2 compressor.
// Resolves the redundant pair with a two-cycle split CPA.
module csa_accum_cpa_19 #(
    parameter int WIDTH     = 19,
    parameter int ACC_WIDTH = 24,
    parameter int MAX_BEATS = 16,
    parameter int LO_WIDTH  = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_c,
    input  logic [WIDTH-1:0]     in_s,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [4:0]           out_beats,
    output logic                 out_trunc
);

    localparam int         HI_WIDTH = ACC_WIDTH - LO_WIDTH;
    localparam logic [4:0] MAX_CNT  = 5'(MAX_BEATS);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        RES_LO,
        RES_HI,
        HOLD
    } state_t;

    state_t state, state_nxt;

    logic [ACC_WIDTH-1:0] acc_s, acc_c;
    logic [ACC_WIDTH-1:0] ext_c, ext_s;
    logic [ACC_WIDTH-1:0] s1, c1, s2, c2;
    logic [4:0]           cnt, cnt_nxt;
    logic [LO_WIDTH-1:0]  lo, lo_nxt;
    logic                 lo_cy, lo_cy_nxt;
    logic [HI_WIDTH-1:0]  hi;
    logic                 accept, close;

    assign in_ready = !reset && (state == IDLE || state == ACCUM);
    assign accept   = in_valid && in_ready;
    assign cnt_nxt  = cnt + 5'd1;
    assign close    = in_last || (cnt_nxt == MAX_CNT);

    assign ext_c = {{(ACC_WIDTH-WIDTH){1'b0}}, in_c};
    assign ext_s = {{(ACC_WIDTH-WIDTH){1'b0}}, in_s};

    // Two 3:2 levels form the 4:2 reduction of {acc_s, acc_c, c, s}
    assign s1 = acc_s ^ acc_c ^ ext_c;
    assign c1 = ((acc_s & acc_c) | (acc_s & ext_c) | (acc_c & ext_c)) << 1;
    assign s2 = s1 ^ c1 ^ ext_s;
    assign c2 = ((s1 & c1) | (s1 & ext_s) | (c1 & ext_s)) << 1;

    assign {lo_cy_nxt, lo_nxt} = {1'b0, acc_s[LO_WIDTH-1:0]}
                               + {1'b0, acc_c[LO_WIDTH-1:0]};

    assign hi = acc_s[ACC_WIDTH-1:LO_WIDTH]
              + acc_c[ACC_WIDTH-1:LO_WIDTH]
              + HI_WIDTH'(lo_cy);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, ACCUM: if (accept) state_nxt = close ? RES_LO : ACCUM;
            RES_LO:      state_nxt = RES_HI;
            RES_HI:      state_nxt = HOLD;
            HOLD:        if (out_ready) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_s     <= '0;
            acc_c     <= '0;
            cnt       <= '0;
            lo        <= '0;
            lo_cy     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_beats <= '0;
            out_trunc <= 1'b0;
        end else begin
            if (accept) begin
                acc_s <= s2;
                acc_c <= c2;
                cnt   <= cnt_nxt;
                if (close) out_trunc <= !in_last;
            end
            if (state == RES_LO) begin
                lo    <= lo_nxt;
                lo_cy <= lo_cy_nxt;
            end
            if (state == RES_HI) begin
                out_sum   <= {hi, lo};
                out_beats <= cnt;
                out_valid <= 1'b1;
            end
            if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
                acc_s     <= '0;
                acc_c     <= '0;
                cnt       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_csa_accum_cpa_19.sv
// Directed bench for csa_accum_cpa_19: vector table plus
// hand-written truncation, hold and reset sequences.
module tb_csa_accum_cpa_19;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [18:0] in_c = '0;
    logic [18:0] in_s = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_sum;
    logic [4:0]  out_beats;
    logic        out_trunc;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [18:0] c;
        logic [18:0] s;
        logic        last;
        logic        chk;
        logic [23:0] sum;
        logic [4:0]  beats;
        logic        trunc;
    } vec_t;

    vec_t v[$];

    always #5 clk = ~clk;

    csa_accum_cpa_19 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_c      (in_c),
        .in_s      (in_s),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_beats (out_beats),
        .out_trunc (out_trunc)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [18:0] c, s,
                                input logic last, chk,
                                input logic [23:0] sum,
                                input logic [4:0] beats,
                                input logic trunc);
        vec_t r;
        r.c = c; r.s = s; r.last = last; r.chk = chk;
        r.sum = sum; r.beats = beats; r.trunc = trunc;
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accept.
    task automatic send_beat(input logic [18:0] c, s, input logic last);
        int n = 0;
        in_c = c; in_s = s; in_last = last; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check("result_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic take_result;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_result(input logic [23:0] sum,
                                input logic [4:0] beats,
                                input logic trunc);
        check("out_sum", {8'd0, out_sum}, {8'd0, sum});
        check("out_beats", {27'd0, out_beats}, {27'd0, beats});
        check("out_trunc", {31'd0, out_trunc}, {31'd0, trunc});
    endtask

    initial begin
        int lat;
        logic [23:0] held_sum;
        logic [4:0]  held_beats;

        v.push_back(mk(19'd4, 19'd3, 1'b0, 1'b0, 24'd0, 5'd0, 1'b0));
        v.push_back(mk(19'd10, 19'd0, 1'b0, 1'b0, 24'd0, 5'd0, 1'b0));
        v.push_back(mk(19'd0, 19'd1, 1'b1, 1'b1, 24'd18, 5'd3, 1'b0));
        v.push_back(mk(19'h40000, 19'h40000, 1'b1, 1'b1,
                       24'h80000, 5'd1, 1'b0));
        for (int i = 1; i <= 16; i++)
            v.push_back(mk(19'h7FFFF, 19'h7FFFF, i == 16, i == 16,
                           24'hFFFFE0, 5'd16, 1'b0));

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_result(24'd0, 5'd0, 1'b0);
        reset = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven frames
        foreach (v[i]) begin
            send_beat(v[i].c, v[i].s, v[i].last);
            if (v[i].chk) begin
                wait_result(lat);
                check("latency", lat, 32'd2);
                check_result(v[i].sum, v[i].beats, v[i].trunc);
                take_result();
            end
        end

        // Frame closed by MAX_BEATS; beat 17 must stall
        for (int i = 0; i < 16; i++)
            send_beat(19'd1, 19'd0, 1'b0);
        in_c = 19'd1; in_s = 19'd0; in_last = 1'b1; in_valid = 1'b1;
        wait_result(lat);
        check("trunc_latency", lat, 32'd2);
        check("stall_ready", {31'd0, in_ready}, 32'd0);
        check_result(24'd16, 5'd16, 1'b1);
        take_result();
        send_beat(19'd1, 19'd0, 1'b1);
        wait_result(lat);
        check_result(24'd1, 5'd1, 1'b0);
        take_result();

        // Back-pressure: result held for 5 cycles
        send_beat(19'd5, 19'd6, 1'b1);
        wait_result(lat);
        held_sum = out_sum;
        held_beats = out_beats;
        check_result(24'd11, 5'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_sum", {8'd0, out_sum}, {8'd0, held_sum});
            check("hold_beats", {27'd0, out_beats}, {27'd0, held_beats});
            check("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        take_result();

        // Reset in the middle of a frame discards it
        for (int i = 0; i < 3; i++)
            send_beat(19'd7, 19'd7, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        send_beat(19'd2, 19'd2, 1'b1);
        wait_result(lat);
        check("post_rst_latency", lat, 32'd2);
        check_result(24'd4, 5'd1, 1'b0);
        take_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
